mux_core: RTL and testbench

Registered 2-input, 2-output function multiplexer. A 2-bit `select` chooses how single-bit inputs `inx`/`iny` map onto outputs `outv`/`outw`: pass, swap, AND/OR, or XOR/XNOR. All inputs may change asynchronously to `clk`, so they are synchronized before use, and both outputs are registered. The block is a leaf cell used wherever a small selectable logic routing point is needed.

---
 rtl/mux_core_pkg.sv | 19 +
 rtl/sync_cell.sv | 32 +++
 rtl/mux_core.sv | 69 ++++++
 tb/tb_mux_core.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_core_pkg.sv
// Shared select encodings, result payload and limits for the mux_core leaf cell.
package mux_core_pkg;

    localparam int unsigned MAX_SYNC_STAGES = 4;
    localparam int unsigned SEL_W           = 2;

    typedef enum logic [SEL_W-1:0] {
        SEL_PASS  = 2'b00,
        SEL_SWAP  = 2'b01,
        SEL_ANDOR = 2'b10,
        SEL_XOR   = 2'b11
    } sel_e;

    typedef struct packed {
        logic v;
        logic w;
    } mux_out_t;

endpackage : mux_core_pkg

// File: rtl/sync_cell.sv
// Single-bit reset-to-zero synchronizer chain; STAGES = 0 degenerates to a wire.
module sync_cell #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_sync
            logic [STAGES-1:0] q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else begin
                    q[0] <= din;
                    for (int i = 1; i < int'(STAGES); i++) begin
                        q[i] <= q[i-1];
                    end
                end
            end

            assign dout = q[STAGES-1];
        end
    endgenerate

endmodule : sync_cell

// File: rtl/mux_core.sv
// Registered 2-in/2-out function multiplexer with per-bit input synchronizers.
module mux_core
    import mux_core_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inx,
    input  logic       iny,
    input  logic [1:0] select,
    output logic       outv,
    output logic       outw
);

    generate
        if (SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
            $error("mux_core: SYNC_STAGES out of range");
        end
    endgenerate

    logic             sx;
    logic             sy;
    logic [SEL_W-1:0] ss_bits;
    sel_e             ss;
    mux_out_t         res_c;

    // Select bits are synchronized independently; brief mixed codes are tolerated.
    sync_cell #(.STAGES(SYNC_STAGES)) u_sync_x  (.clk(clk), .rst_n(rst_n), .din(inx),       .dout(sx));
    sync_cell #(.STAGES(SYNC_STAGES)) u_sync_y  (.clk(clk), .rst_n(rst_n), .din(iny),       .dout(sy));
    sync_cell #(.STAGES(SYNC_STAGES)) u_sync_s0 (.clk(clk), .rst_n(rst_n), .din(select[0]), .dout(ss_bits[0]));
    sync_cell #(.STAGES(SYNC_STAGES)) u_sync_s1 (.clk(clk), .rst_n(rst_n), .din(select[1]), .dout(ss_bits[1]));

    assign ss = sel_e'(ss_bits);

    always_comb begin
        res_c = '0;
        case (ss)
            SEL_PASS: begin
                res_c.v = sx;
                res_c.w = sy;
            end
            SEL_SWAP: begin
                res_c.v = sy;
                res_c.w = sx;
            end
            SEL_ANDOR: begin
                res_c.v = sx & sy;
                res_c.w = sx | sy;
            end
            SEL_XOR: begin
                res_c.v = sx ^ sy;
                res_c.w = ~(sx ^ sy);
            end
            default: res_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outv <= 1'b0;
            outw <= 1'b0;
        end else begin
            outv <= res_c.v;
            outw <= res_c.w;
        end
    end

endmodule : mux_core

// File: tb/tb_mux_core.sv
// Self-checking bench for mux_core: two instances (2-stage and bypass synchronizers) share stimulus.
module tb_mux_core;

    typedef struct packed {
        logic [1:0] sel;
        logic       x;
        logic       y;
    } smp_t;

    typedef struct {
        logic [1:0] sel;
        logic       x;
        logic       y;
        logic       v;
        logic       w;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       inx;
    logic       iny;
    logic [1:0] select;
    logic       outv2, outw2;
    logic       outv0, outw0;

    int   tests;
    int   fails;
    int   tolerated;
    smp_t hist[$];
    vec_t vecs[16];

    mux_core #(.SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .inx(inx), .iny(iny), .select(select),
        .outv(outv2), .outw(outw2)
    );

    mux_core #(.SYNC_STAGES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .inx(inx), .iny(iny), .select(select),
        .outv(outv0), .outw(outw0)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference behaviour as arithmetic on 0/1 integers, returned as {v, w}.
    function automatic logic [1:0] ref_fn(input logic [1:0] sel, input logic x, input logic y);
        int a, b, v, w;
        a = int'(x);
        b = int'(y);
        case (int'(sel))
            0:       begin v = a;           w = b;                      end
            1:       begin v = b;           w = a;                      end
            2:       begin v = a * b;       w = (a + b > 0) ? 1 : 0;    end
            default: begin v = (a + b) % 2; w = (a == b) ? 1 : 0;       end
        endcase
        return {1'(v), 1'(w)};
    endfunction

    function automatic logic mixed_ok(input logic [1:0] prev, input logic [1:0] cur,
                                      input logic x, input logic y, input logic [1:0] act);
        logic [1:0] c;
        for (int m = 0; m < 4; m++) begin
            c[1] = m[1] ? cur[1] : prev[1];
            c[0] = m[0] ? cur[0] : prev[0];
            if (ref_fn(c, x, y) === act) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {v,w}=%b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pre-history after reset is all-zero inputs, matching the cleared synchronizers.
    task automatic reseed();
        hist.delete();
        repeat (6) hist.push_back('0);
    endtask

    task automatic sample_inputs();
        if (rst_n) begin
            hist.push_back({select, inx, iny});
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    function automatic logic [1:0] model_out(input int s);
        smp_t e;
        e = hist[hist.size() - 1 - s];
        return ref_fn(e.sel, e.x, e.y);
    endfunction

    task automatic check_model();
        check("model_s2", {outv2, outw2}, model_out(2));
        check("model_s0", {outv0, outw0}, model_out(0));
    endtask

    task automatic step();
        @(posedge clk);
        sample_inputs();
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic score(input string name, input int s, input logic [1:0] act);
        smp_t cur, prv;
        cur = hist[hist.size() - 1 - s];
        prv = hist[hist.size() - 2 - s];
        if (act !== ref_fn(cur.sel, cur.x, cur.y) && cur.sel != prv.sel &&
            mixed_ok(prv.sel, cur.sel, cur.x, cur.y, act)) begin
            tests++;
            tolerated++;
        end else begin
            check(name, act, ref_fn(cur.sel, cur.x, cur.y));
        end
    endtask

    initial begin
        int lat2, lat0;

        tests     = 0;
        fails     = 0;
        tolerated = 0;

        vecs[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{2'b00, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset held with inputs that would otherwise drive outw high.
        rst_n  = 1'b0;
        inx    = 1'b1;
        iny    = 1'b1;
        select = 2'b11;
        reseed();
        #1;
        check("reset_s2", {outv2, outw2}, 2'b00);
        check("reset_s0", {outv0, outw0}, 2'b00);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        check("reset_release_s2", {outv2, outw2}, 2'b01);

        // PASS then SWAP with x=1, y=0.
        inx = 1'b1; iny = 1'b0; select = 2'b00;
        repeat (3) step();
        check("pass_s2", {outv2, outw2}, 2'b10);
        select = 2'b01;
        repeat (3) step();
        check("swap_s2", {outv2, outw2}, 2'b01);

        // Table sweep of all 16 {select, inx, iny} combinations.
        for (int i = 0; i < 16; i++) begin
            select = vecs[i].sel;
            inx    = vecs[i].x;
            iny    = vecs[i].y;
            repeat (5) step();
            check($sformatf("table%0d_s2", i), {outv2, outw2}, {vecs[i].v, vecs[i].w});
            check($sformatf("table%0d_s0", i), {outv0, outw0}, {vecs[i].v, vecs[i].w});
        end

        // Latency: count rising edges until outv follows a toggle of inx.
        select = 2'b00; inx = 1'b0; iny = 1'b0;
        repeat (5) step();
        lat2 = 0;
        lat0 = 0;
        inx  = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            sample_inputs();
            #1;
            if (lat2 == 0 && outv2) lat2 = n;
            if (lat0 == 0 && outv0) lat0 = n;
            @(negedge clk);
        end
        check_int("latency_s2", lat2, 3);
        check_int("latency_s0", lat0, 1);

        // Reset pulse between edges clears outputs without a clock edge.
        select = 2'b11; inx = 1'b1; iny = 1'b0;
        repeat (5) step();
        check("pre_async_s2", {outv2, outw2}, 2'b10);
        @(posedge clk);
        sample_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_s2", {outv2, outw2}, 2'b00);
        check("async_rst_s0", {outv0, outw0}, 2'b00);
        reseed();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step();

        // Free-running stimulus on edges that never coincide with clk.
        select = 2'b00; inx = 1'b0; iny = 1'b0;
        repeat (4) step();
        #1;
        fork
            begin
                repeat (6000) begin
                    #40 select = select + 2'd1;
                end
            end
            begin
                repeat (3000) begin
                    #80 inx = ~inx;
                end
            end
            begin
                repeat (375) begin
                    #640 iny = ~iny;
                end
            end
            begin
                repeat (30000) begin
                    @(posedge clk);
                    sample_inputs();
                    #1;
                    score("free_s2", 2, {outv2, outw2});
                    score("free_s0", 0, {outv0, outw0});
                end
            end
        join

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mux_core
